imem_loader_arb: RTL and testbench

Shares the single-port instruction memory between the core's fetch path and a byte-stream program loader (UART/JTAG bootloader side). In normal operation the fetch address passes straight to the memory. During a load session the core is stalled and fed NOPs while bytes are assembled into 32-bit little-endian words and written sequentially from a base address. The block sits between the core's fetch stage and the instruction memory.

---
 rtl/imem_loader_arb.sv | 136 +++++++++++++
 tb/tb_imem_loader_arb.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_arb.sv
// Instruction-memory arbiter: fetch passthrough in IDLE, byte-stream loader writes LE words while the core is stalled.
// Latency: fetch is combinational (zero latency); one word write every 4 accepted bytes + 1 WRITE cycle.
// Backpressure: ld_ready only in COLLECT; the core is stalled with NOPs for the whole session.
// Optional: define IMEM_LOAD_CSUM_EN to add the ld_csum running-sum output.
module imem_loader_arb #(
  parameter int unsigned ADDR_W   = 12,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_abort,
  input  logic [7:0]        ld_byte,
  input  logic              ld_valid,
  output logic              ld_ready,
  output logic              ld_busy,
  output logic              ld_done,
`ifdef IMEM_LOAD_CSUM_EN
  output logic [31:0]       ld_csum,
`endif
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [31:0]       fetch_data,
  output logic              fetch_stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_en,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_WRITE   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W:0]   len_q;
  logic [ADDR_W:0]   wcnt_q;
  logic [ADDR_W:0]   wcnt_d;
  logic [1:0]        idx_q;
  logic [31:0]       asm_q;
  logic [ADDR_W-1:0] wr_addr;

  // Next word count and the wrapping write address for the current word.
  assign wcnt_d  = wcnt_q + 1'b1;
  assign wr_addr = base_q + wcnt_q[ADDR_W-1:0];

`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0] csum_q;
  logic [31:0] csum_d;
  assign csum_d  = csum_q + asm_q;
  assign ld_csum = csum_q;

  // Running sum of committed words; cleared on accepted start, held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (state_q == S_IDLE && ld_start) begin
      csum_q <= '0;
    end else if (state_q == S_WRITE && !ld_abort) begin
      csum_q <= csum_d;
    end
  end
`endif

  // Session FSM plus byte assembly; abort wins over the write in WRITE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      idx_q   <= '0;
      asm_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ld_start) begin
            base_q  <= ld_base;
            len_q   <= ld_len;
            wcnt_q  <= '0;
            idx_q   <= '0;
            asm_q   <= '0;
            state_q <= (ld_len == '0) ? S_DONE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (ld_abort) begin
            state_q <= S_IDLE;
          end else if (ld_valid) begin
            asm_q[{idx_q, 3'b000} +: 8] <= ld_byte;
            idx_q <= idx_q + 2'd1;
            if (idx_q == 2'd3) begin
              state_q <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (ld_abort) begin
            state_q <= S_IDLE;
          end else begin
            wcnt_q  <= wcnt_d;
            state_q <= (wcnt_d == len_q) ? S_DONE : S_COLLECT;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state; only mem_en sees the abort input.
  always_comb begin
    mem_addr    = fetch_addr;
    fetch_data  = mem_rdata;
    fetch_stall = 1'b0;
    ld_busy     = 1'b0;
    if (state_q != S_IDLE) begin
      mem_addr    = wr_addr;
      fetch_data  = NOP_WORD;
      fetch_stall = 1'b1;
      ld_busy     = 1'b1;
    end
    ld_ready = (state_q == S_COLLECT);
    ld_done  = (state_q == S_DONE);
    mem_en   = (state_q == S_WRITE) && !ld_abort;
  end

  assign mem_wdata = asm_q;

endmodule

// File: tb/tb_imem_loader_arb.sv
module tb_imem_loader_arb;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ld_start, ld_abort, ld_valid;
  logic [11:0] ld_base;
  logic [12:0] ld_len;
  logic [7:0]  ld_byte;
  logic        ld_ready, ld_busy, ld_done;
  logic [11:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic [11:0] mem_addr;
  logic        mem_en;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef IMEM_LOAD_CSUM_EN
  logic [31:0] ld_csum;
`endif

  imem_loader_arb dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_abort(ld_abort), .ld_byte(ld_byte), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_busy(ld_busy), .ld_done(ld_done),
`ifdef IMEM_LOAD_CSUM_EN
    .ld_csum(ld_csum),
`endif
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
    .mem_addr(mem_addr), .mem_en(mem_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Physical memory driven by the DUT; ref_mem is the expected image.
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_en) mem[mem_addr] <= mem_wdata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  stim[$];
  logic [11:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int obs_done_n, obs_done_cyc, obs_last_wr_cyc, obs_end_cyc, obs_nop_bad, obs_busy_bad;

  function automatic logic [31:0] exp_word(int w);
    return {stim[4*w+3], stim[4*w+2], stim[4*w+1], stim[4*w]};
  endfunction

  function automatic logic [31:0] exp_sum(int n);
    logic [31:0] s = '0;
    for (int w = 0; w < n; w++) s = s + exp_word(w);
    return s;
  endfunction

  function automatic void commit_ref(logic [11:0] base, int n);
    for (int w = 0; w < n; w++) ref_mem[12'(int'(base) + w)] = exp_word(w);
  endfunction

  // Drives one session from stim, recording writes and handshake observations.
  task automatic do_session(input logic [11:0] base, input logic [12:0] len, input int gap_pct,
                            input int abort_cyc, input int abort_done_cyc, input bit abort_at_start);
    int bi;
    bi = 0;
    obs_addr.delete(); obs_data.delete();
    obs_done_n = 0; obs_done_cyc = -1; obs_last_wr_cyc = -1; obs_end_cyc = -1;
    obs_nop_bad = 0; obs_busy_bad = 0;
    @(negedge clk);
    ld_start = 1'b1; ld_base = base; ld_len = len; ld_valid = 1'b0; ld_abort = abort_at_start;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      if (!fetch_stall) begin
        obs_end_cyc = cyc;
        break;
      end
      ld_start = ($urandom_range(0, 3) == 0);
      ld_base  = 12'($urandom);
      ld_len   = 13'($urandom_range(1, 8));
      ld_abort = (cyc == abort_cyc) || (cyc == abort_done_cyc);
      ld_valid = (bi < stim.size()) && ($urandom_range(0, 99) >= gap_pct);
      ld_byte  = (bi < stim.size()) ? stim[bi] : 8'($urandom);
      #1;
      if (fetch_data !== NOP) obs_nop_bad++;
      if (ld_busy !== 1'b1) obs_busy_bad++;
      if (mem_en) begin
        obs_addr.push_back(mem_addr);
        obs_data.push_back(mem_wdata);
        obs_last_wr_cyc = cyc;
      end
      if (ld_done) begin
        obs_done_n++;
        obs_done_cyc = cyc;
      end
      if (ld_ready && ld_valid) bi++;
    end
    ld_start = 1'b0; ld_abort = 1'b0; ld_valid = 1'b0;
  endtask

  task automatic fill_stim(int nbytes);
    stim.delete();
    for (int i = 0; i < nbytes; i++) stim.push_back(8'($urandom));
  endtask

  task automatic test_reset;
    rst = 1'b1; ld_start = 0; ld_abort = 0; ld_valid = 0; ld_byte = 0;
    ld_base = 0; ld_len = 0; fetch_addr = 12'h123;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (ld_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ld_busy); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", ld_ready); end
    checks++; if (ld_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", ld_done); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
    checks++; if (fetch_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", fetch_stall); end
    checks++; if (mem_addr !== 12'h123) begin errors++; $display("FAIL reset_mem_addr: got %h want 123", mem_addr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_word;
    stim.delete();
    stim.push_back(8'h13); stim.push_back(8'h05); stim.push_back(8'h10); stim.push_back(8'h00);
    do_session(12'h010, 13'd1, 0, -1, 6, 1'b1);
    checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL single_nwrites: got %0d want 1", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] !== 12'h010) begin errors++; $display("FAIL single_addr: got %h want 010", obs_addr[0]); end
      checks++; if (obs_data[0] !== 32'h0010_0513) begin errors++; $display("FAIL single_data: got %h want 00100513", obs_data[0]); end
    end
    checks++; if (obs_done_n != 1 || obs_done_cyc != 6) begin errors++; $display("FAIL single_done: got n=%0d cyc=%0d want n=1 cyc=6", obs_done_n, obs_done_cyc); end
    checks++; if (obs_end_cyc != 7) begin errors++; $display("FAIL single_latency: got %0d want 7", obs_end_cyc); end
    checks++; if (obs_nop_bad != 0 || obs_busy_bad != 0) begin errors++; $display("FAIL single_stall_out: got nop_bad=%0d busy_bad=%0d want 0", obs_nop_bad, obs_busy_bad); end
`ifdef IMEM_LOAD_CSUM_EN
    checks++; if (ld_csum !== 32'h0010_0513) begin errors++; $display("FAIL single_csum: got %h want 00100513", ld_csum); end
`endif
    commit_ref(12'h010, 1);
    fetch_addr = 12'h010; #1;
    checks++; if (fetch_data !== 32'h0010_0513) begin errors++; $display("FAIL single_fetch: got %h want 00100513", fetch_data); end
  endtask

  task automatic test_wrap;
    fill_stim(8);
    do_session(12'hFFF, 13'd2, 0, -1, -1, 1'b0);
    checks++; if (obs_addr.size() != 2) begin errors++; $display("FAIL wrap_nwrites: got %0d want 2", obs_addr.size()); end
    else begin
      checks++; if (obs_addr[0] !== 12'hFFF || obs_addr[1] !== 12'h000) begin errors++; $display("FAIL wrap_addr: got %h,%h want fff,000", obs_addr[0], obs_addr[1]); end
      checks++; if (obs_data[0] !== exp_word(0) || obs_data[1] !== exp_word(1)) begin errors++; $display("FAIL wrap_data: got %h,%h want %h,%h", obs_data[0], obs_data[1], exp_word(0), exp_word(1)); end
    end
    checks++; if (obs_end_cyc != 12) begin errors++; $display("FAIL wrap_latency: got %0d want 12", obs_end_cyc); end
    commit_ref(12'hFFF, 2);
  endtask

  task automatic test_gapped;
    logic [11:0] base;
    base = 12'($urandom);
    fill_stim(12);
    do_session(base, 13'd3, 40, -1, -1, 1'b0);
    checks++; if (obs_addr.size() != 3) begin errors++; $display("FAIL gap_nwrites: got %0d want 3", obs_addr.size()); end
    else begin
      for (int w = 0; w < 3; w++) begin
        checks++;
        if (obs_addr[w] !== 12'(int'(base) + w) || obs_data[w] !== exp_word(w)) begin
          errors++; $display("FAIL gap_word%0d: got %h@%h want %h@%h", w, obs_data[w], obs_addr[w], exp_word(w), 12'(int'(base) + w));
        end
      end
    end
    checks++; if (obs_done_n != 1 || obs_done_cyc != obs_last_wr_cyc + 1 || obs_end_cyc != obs_done_cyc + 1) begin
      errors++; $display("FAIL gap_done_timing: got n=%0d done=%0d lastwr=%0d end=%0d", obs_done_n, obs_done_cyc, obs_last_wr_cyc, obs_end_cyc); end
    checks++; if (obs_nop_bad != 0) begin errors++; $display("FAIL gap_nop: got %0d non-NOP cycles want 0", obs_nop_bad); end
`ifdef IMEM_LOAD_CSUM_EN
    checks++; if (ld_csum !== exp_sum(3)) begin errors++; $display("FAIL gap_csum: got %h want %h", ld_csum, exp_sum(3)); end
`endif
    commit_ref(base, 3);
    for (int w = 0; w < 3; w++) begin
      fetch_addr = 12'(int'(base) + w); #1;
      checks++; if (fetch_data !== ref_mem[fetch_addr] || fetch_stall !== 1'b0) begin
        errors++; $display("FAIL gap_fetch%0d: got %h stall=%b want %h stall=0", w, fetch_data, fetch_stall, ref_mem[fetch_addr]); end
    end
  endtask

  task automatic test_abort;
    logic [11:0] base;
    logic [31:0] old1;
    base = 12'h400;
    old1 = ref_mem[12'h401];
    fill_stim(12);
    do_session(base, 13'd3, 0, 10, -1, 1'b0);
    checks++; if (obs_addr.size() != 1) begin errors++; $display("FAIL abort_nwrites: got %0d want 1", obs_addr.size()); end
    checks++; if (obs_done_n != 0) begin errors++; $display("FAIL abort_done: got %0d pulses want 0", obs_done_n); end
    checks++; if (obs_end_cyc != 11) begin errors++; $display("FAIL abort_idle: got %0d want 11", obs_end_cyc); end
`ifdef IMEM_LOAD_CSUM_EN
    checks++; if (ld_csum !== exp_sum(1)) begin errors++; $display("FAIL abort_csum: got %h want %h", ld_csum, exp_sum(1)); end
`endif
    commit_ref(base, 1);
    fetch_addr = 12'h400; #1;
    checks++; if (fetch_data !== exp_word(0)) begin errors++; $display("FAIL abort_kept: got %h want %h", fetch_data, exp_word(0)); end
    fetch_addr = 12'h401; #1;
    checks++; if (fetch_data !== old1) begin errors++; $display("FAIL abort_nowrite: got %h want %h", fetch_data, old1); end
  endtask

  task automatic test_len0;
    stim.delete();
    do_session(12'h555, 13'd0, 0, -1, -1, 1'b1);
    checks++; if (obs_addr.size() != 0) begin errors++; $display("FAIL len0_nwrites: got %0d want 0", obs_addr.size()); end
    checks++; if (obs_done_n != 1 || obs_done_cyc != 1) begin errors++; $display("FAIL len0_done: got n=%0d cyc=%0d want n=1 cyc=1", obs_done_n, obs_done_cyc); end
    checks++; if (obs_end_cyc != 2) begin errors++; $display("FAIL len0_latency: got %0d want 2", obs_end_cyc); end
`ifdef IMEM_LOAD_CSUM_EN
    checks++; if (ld_csum !== 32'h0) begin errors++; $display("FAIL len0_csum: got %h want 0", ld_csum); end
`endif
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ld_start = 1'b1; ld_base = 12'h200; ld_len = 13'd1;
    @(negedge clk);
    ld_start = 1'b0; ld_valid = 1'b1; ld_byte = 8'hAA;
    @(negedge clk);
    ld_byte = 8'hBB;
    @(negedge clk);
    ld_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; #1;
    checks++; if (ld_busy !== 1'b0 || ld_ready !== 1'b0 || fetch_stall !== 1'b0 || mem_en !== 1'b0 || ld_done !== 1'b0) begin
      errors++; $display("FAIL rstmid_outputs: got busy=%b rdy=%b stall=%b en=%b done=%b want all 0", ld_busy, ld_ready, fetch_stall, mem_en, ld_done); end
    fill_stim(4);
    do_session(12'h200, 13'd1, 0, -1, -1, 1'b0);
    checks++; if (obs_addr.size() != 1 || obs_data[0] !== exp_word(0) || obs_addr[0] !== 12'h200) begin
      errors++; $display("FAIL rstmid_clean: got n=%0d data=%h want n=1 data=%h@200", obs_addr.size(), (obs_data.size() > 0) ? obs_data[0] : 32'h0, exp_word(0)); end
    commit_ref(12'h200, 1);
  endtask

  task automatic test_back_to_back;
    logic [11:0] base;
    int len, gap;
    for (int s = 0; s < 4; s++) begin
      base = 12'($urandom);
      len  = $urandom_range(1, 5);
      gap  = (s % 2 == 0) ? 0 : 30;
      fill_stim(4 * len);
      do_session(base, 13'(len), gap, -1, -1, 1'b0);
      checks++; if (obs_addr.size() != len) begin errors++; $display("FAIL b2b%0d_nwrites: got %0d want %0d", s, obs_addr.size(), len); end
      else begin
        for (int w = 0; w < len; w++) begin
          checks++;
          if (obs_addr[w] !== 12'(int'(base) + w) || obs_data[w] !== exp_word(w)) begin
            errors++; $display("FAIL b2b%0d_word%0d: got %h@%h want %h@%h", s, w, obs_data[w], obs_addr[w], exp_word(w), 12'(int'(base) + w));
          end
        end
      end
      if (gap == 0) begin
        checks++; if (obs_end_cyc != 5 * len + 2) begin errors++; $display("FAIL b2b%0d_latency: got %0d want %0d", s, obs_end_cyc, 5 * len + 2); end
      end
      checks++; if (obs_done_n != 1) begin errors++; $display("FAIL b2b%0d_done: got %0d want 1", s, obs_done_n); end
      commit_ref(base, len);
      fetch_addr = base; #1;
      checks++; if (fetch_data !== ref_mem[base]) begin errors++; $display("FAIL b2b%0d_fetch: got %h want %h", s, fetch_data, ref_mem[base]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = 32'h0;
    test_reset;
    test_single_word;
    test_wrap;
    test_gapped;
    test_abort;
    test_len0;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
